acc_bank: RTL

Parametrised per-core accumulator bank for the multicore matrix-multiplication datapath, replacing the single 16-bit accumulator with NUM_CORES independent lanes. Each lane accepts an encoded operation per cycle (load, increment, decrement, clear, ALU write, add) and keeps sticky overflow and zero flags. A drain engine streams every lane's result out over a valid/ready port and can clear lanes as they are read, so the controller collects a finished matrix tile without per-core reads.

---
 rtl/acc_pkg.sv | 20 ++
 rtl/acc_lane.sv | 86 ++++++++
 rtl/acc_bank.sv | 102 ++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared opcode and drain-FSM encodings for the accumulator bank.
package acc_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_INC  = 3'd2,
      OP_DEC  = 3'd3,
      OP_CLR  = 3'd4,
      OP_ALU  = 3'd5,
      OP_ADD  = 3'd6,
      OP_RSVD = 3'd7
   } acc_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } drain_state_e;

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: opcode decode, modular/saturating arithmetic, sticky ovf.
// Saturating INC/ADD/DEC selected by defining ACC_SAT_EN.
module acc_lane
   import acc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic              freeze_i,
   input  logic              drain_clr_i,
   output logic [DATA_W-1:0] acc_o,
   output logic              ovf_o
);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] addend;
   logic              borrow;
   acc_op_e           op_e;

   assign op_e = acc_op_e'(op_i);

   always_comb begin
      addend = (op_e == OP_ADD) ? data_i : DATA_W'(1);
      sum    = {1'b0, acc_q} + {1'b0, addend};
      borrow = (acc_q == '0);
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      // Drain clear wins over freeze: it is the only update allowed while busy.
      if (drain_clr_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (!freeze_i) begin
         case (op_e)
            OP_LOAD: begin
               acc_d = data_i;
               ovf_d = 1'b0;
            end
            OP_INC, OP_ADD: begin
`ifdef ACC_SAT_EN
               acc_d = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
               acc_d = sum[DATA_W-1:0];
`endif
               if (sum[DATA_W]) ovf_d = 1'b1;
            end
            OP_DEC: begin
`ifdef ACC_SAT_EN
               acc_d = borrow ? '0 : acc_q - DATA_W'(1);
`else
               acc_d = acc_q - DATA_W'(1);
`endif
               if (borrow) ovf_d = 1'b1;
            end
            OP_CLR: begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
            OP_ALU: begin
               acc_d = alu_i;
               ovf_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_bank.sv
// NUM_CORES-lane accumulator bank with a valid/ready drain engine.
// Define ACC_SAT_EN for saturating lane arithmetic (wrap-around otherwise).
module acc_bank
   import acc_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [3*NUM_CORES-1:0]      op,
   input  logic [DATA_W*NUM_CORES-1:0] data_in,
   input  logic [DATA_W*NUM_CORES-1:0] alu_out,
   output logic [DATA_W*NUM_CORES-1:0] data_out,
   output logic [NUM_CORES-1:0]        ovf,
   output logic [NUM_CORES-1:0]        zero,
   input  logic                        drain_start,
   input  logic                        drain_clear,
   output logic                        busy,
   output logic                        drain_valid,
   input  logic                        drain_ready,
   output logic [DATA_W-1:0]           drain_data,
   output logic [IDX_W-1:0]            drain_idx,
   output logic                        drain_last
);

   drain_state_e                       state_q;
   logic [IDX_W-1:0]                   idx_q;
   logic                               clr_q;
   logic [NUM_CORES-1:0][DATA_W-1:0]   acc_w;
   logic [NUM_CORES-1:0]               lane_clr;
   logic                               accept;
   logic                               at_last;
   logic [DATA_W-1:0]                  sel_data;

   assign busy    = (state_q == ST_DRAIN);
   assign accept  = busy && drain_ready;
   assign at_last = (idx_q == IDX_W'(NUM_CORES - 1));

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
      assign lane_clr[i] = accept && clr_q && (idx_q == IDX_W'(i));

      acc_lane #(.DATA_W(DATA_W)) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .op_i       (op[3*i +: 3]),
         .data_i     (data_in[DATA_W*i +: DATA_W]),
         .alu_i      (alu_out[DATA_W*i +: DATA_W]),
         .freeze_i   (busy),
         .drain_clr_i(lane_clr[i]),
         .acc_o      (acc_w[i]),
         .ovf_o      (ovf[i])
      );

      assign zero[i] = (acc_w[i] == '0);
   end

   assign data_out = acc_w;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         clr_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (drain_start) begin
                  state_q <= ST_DRAIN;
                  idx_q   <= '0;
                  clr_q   <= drain_clear;
               end
            end
            ST_DRAIN: begin
               if (drain_ready) begin
                  if (at_last) begin
                     state_q <= ST_IDLE;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Loop-based select keeps the mux in range for non-power-of-two lane counts.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CORES; i++)
         if (idx_q == IDX_W'(i)) sel_data = acc_w[i];
   end

   assign drain_valid = busy;
   assign drain_data  = busy ? sel_data : '0;
   assign drain_idx   = busy ? idx_q : '0;
   assign drain_last  = busy && at_last;

endmodule
